adc_power_sequencer: RTL and testbench
======================================

// Module: adc_power_sequencer
// PURPOSE
//   Brings up the ADC front end in order: supply, reference, IO, diff amp, op amp, then ADC reset
//   release. It then sends NUM_CMDS init command words on the ADC command AXIS channel.
//   Sits between the AXI-Lite config block and the ADC core.
//   After init it arbitrates the command channel: the config block's AXIS words pass through only in RUN.
// PARAMETERS
//   NUM_CMDS  4   init command words sent after reset release (1..15)
//   DELAY_W   24  width of the per-step delay counter
// PORTS
//   aclk           in   1            clock; all logic on rising edge
//   areset         in   1            synchronous, active-high reset
//   start          in   1            one-cycle pulse: begin power-up (honoured only in IDLE)
//   stop           in   1            one-cycle pulse: power down, return to IDLE
//   step_delay     in   DELAY_W      wait cycles per step, sampled on entry to each step
//   init_cmds      in   32*NUM_CMDS  init words; word i = bits [32*i+31:32*i], sent i=0 first
//   pwr_en/ref_en/io_en/diffamp_en/opamp_en  out 1 each  front-end enables, registered
//   adc_resetn     out  1            ADC core reset, active-low, registered
//   s_axis_tdata   in   32           pass-through command words from config block
//   s_axis_tvalid  in   1
//   s_axis_tready  out  1
//   m_axis_tdata   out  32           command words to ADC
//   m_axis_tvalid  out  1
//   m_axis_tready  in   1
//   seq_state      out  3            current state encoding (below)
//   ready          out  1            1 iff state==RUN
// BEHAVIOUR
//   Reset: state IDLE; all enables 0; adc_resetn 0; m_axis_tvalid 0; s_axis_tready 0; cmd index 0.
//   States: IDLE=0, PWR=1, RELEASE=2, CMD=3, RUN=4, DRAIN=5; other codes go to IDLE.
//   IDLE:
//     start & !stop -> PWR at step 0; pwr_en=1 on the next cycle.
//     Start in any other state is ignored.
//   PWR (step k = 0..4):
//     On entering step k, set enable k (order: pwr, ref, io, diffamp, opamp) and load cnt=step_delay.
//     cnt decrements each cycle. At cnt==0, advance: to step k+1, or from step 4 to RELEASE.
//     Each step therefore lasts step_delay+1 cycles. Earlier enables stay set.
//   RELEASE: adc_resetn=1 on entry; load cnt=step_delay; at cnt==0 go to CMD.
//   CMD:
//     m_axis_tvalid=1; m_axis_tdata=init_cmds word[idx].
//     tdata/tvalid are held stable until tvalid&tready.
//     On each handshake idx++. Handshake on idx==NUM_CMDS-1 -> RUN; m_axis_tvalid drops the same edge.
//   RUN:
//     m_axis_tdata=s_axis_tdata; m_axis_tvalid=s_axis_tvalid; s_axis_tready=m_axis_tready (combinational).
//     In all other states s_axis_tready=0.
//   stop, any state, outside the drain cases below: next cycle go to IDLE.
//     All enables=0, adc_resetn=0 simultaneously; idx and cnt cleared.
//   stop in CMD with tvalid&!tready -> DRAIN. Hold word until handshake, then IDLE.
//   stop in RUN with s_axis_tvalid&!m_axis_tready -> DRAIN.
//     DRAIN keeps pass-through until that handshake, then IDLE.
//   stop has priority over start in the same cycle. stop in IDLE is a no-op.
//   areset overrides all states, including DRAIN and mid-transfer.
//   step_delay changes take effect only at the next step entry.
// TESTING
//   T1 reset: assert areset 2 cycles -> all enables 0, adc_resetn 0, m_axis_tvalid 0, seq_state 0.
//   T2 power-up: NUM_CMDS=2, step_delay=3, tready=1, start at cycle 0.
//      pwr_en@1, ref_en@5, io_en@9, diffamp_en@13, opamp_en@17, adc_resetn@21.
//      Words 0/1 handshake @25/26; ready@27.
//   T3 backpressure: tready=0 for 5 cycles in CMD.
//      tvalid stays 1, tdata=word0 stable; idx advances only on the handshake.
//   T4 stop in PWR step 2: next cycle all enables 0, IDLE. A later start repeats T2 timing.
//   T5 RUN pass-through: 0xA5A5_0001 forwarded unchanged.
//      Then stop while s_axis_tvalid=1, tready=0 -> DRAIN.
//      tready=1 completes the transfer -> IDLE, enables 0.
//   T6 start and stop in the same cycle -> stays IDLE.
//      step_delay=0 -> each PWR step lasts 1 cycle (enables @1..5, adc_resetn @6).

Source files
------------

// File: rtl/adc_power_sequencer.sv
// adc_power_sequencer: ordered ADC front-end power-up, init command burst, then command pass-through.
// Latency: enables/adc_resetn registered (1 cycle after the deciding edge); each step lasts step_delay+1 cycles.
// Backpressure: init words held until m_axis_tready; in RUN/pass-through drain, s_axis_tready = m_axis_tready.
//
// Ports:
//   aclk, areset              clock, synchronous active-high reset
//   start, stop               one-cycle control pulses (stop wins over start)
//   step_delay                per-step wait, sampled on entry to each step
//   init_cmds                 NUM_CMDS init words, word 0 in the low 32 bits
//   pwr/ref/io/diffamp/opamp_en, adc_resetn   registered front-end controls
//   s_axis_*                  command words from the config block (passed through in RUN)
//   m_axis_*                  command words to the ADC core
//   seq_state, ready          state encoding, ready = RUN
module adc_power_sequencer #(
  parameter int NUM_CMDS = 4,
  parameter int DELAY_W  = 24
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   start,
  input  logic                   stop,
  input  logic [DELAY_W-1:0]     step_delay,
  input  logic [32*NUM_CMDS-1:0] init_cmds,
  output logic                   pwr_en,
  output logic                   ref_en,
  output logic                   io_en,
  output logic                   diffamp_en,
  output logic                   opamp_en,
  output logic                   adc_resetn,
  input  logic [31:0]            s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [31:0]            m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [2:0]             seq_state,
  output logic                   ready
);

  localparam int IDX_W = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CMDS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PWR     = 3'd1,
    S_RELEASE = 3'd2,
    S_CMD     = 3'd3,
    S_RUN     = 3'd4,
    S_DRAIN   = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [4:0]         r_en;          // {opamp, diffamp, io, ref, pwr}
  logic               r_resetn;
  logic [DELAY_W-1:0] r_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic [31:0]        r_cmd_dat;     // init word currently offered; registered so it cannot glitch while waiting
  logic               r_drain_run;   // DRAIN entered from RUN (pass-through) rather than from CMD
  logic               w_cnt_done;
  logic               w_cmd_hs;
  logic [IDX_W-1:0]   w_sel_idx;

  assign w_cnt_done = (r_cnt == '0);
  // Index of the word to preload after a handshake; clamped so the last handshake never reads past init_cmds.
  assign w_sel_idx  = (r_idx == LAST_IDX) ? r_idx : r_idx + IDX_W'(1);

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_cmd_hs      = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = r_cmd_dat;
    s_axis_tready = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !stop) w_next = S_PWR;
      end
      S_PWR: begin
        // r_en[4] set means the opamp step (the last one) is in progress.
        if (stop)                        w_next = S_IDLE;
        else if (w_cnt_done && r_en[4])  w_next = S_RELEASE;
      end
      S_RELEASE: begin
        if (stop)            w_next = S_IDLE;
        else if (w_cnt_done) w_next = S_CMD;
      end
      S_CMD: begin
        m_axis_tvalid = 1'b1;
        w_cmd_hs      = m_axis_tready;
        if (stop)                                w_next = w_cmd_hs ? S_IDLE : S_DRAIN;
        else if (w_cmd_hs && r_idx == LAST_IDX)  w_next = S_RUN;
      end
      S_RUN: begin
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tdata  = s_axis_tdata;
        s_axis_tready = m_axis_tready;
        if (stop) w_next = (s_axis_tvalid && !m_axis_tready) ? S_DRAIN : S_IDLE;
      end
      S_DRAIN: begin
        if (r_drain_run) begin
          m_axis_tvalid = s_axis_tvalid;
          m_axis_tdata  = s_axis_tdata;
          s_axis_tready = m_axis_tready;
          if (s_axis_tvalid && m_axis_tready) w_next = S_IDLE;
        end else begin
          m_axis_tvalid = 1'b1;
          if (m_axis_tready) w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_en        <= '0;
      r_resetn    <= 1'b0;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_cmd_dat   <= '0;
      r_drain_run <= 1'b0;
    end else if (w_next == S_IDLE) begin
      // Every exit to IDLE drops all supplies and the ADC reset together.
      r_en        <= '0;
      r_resetn    <= 1'b0;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_drain_run <= 1'b0;
    end else begin
      if (w_next == S_DRAIN && r_state != S_DRAIN) r_drain_run <= (r_state == S_RUN);
      case (r_state)
        S_IDLE: begin
          r_en  <= 5'b00001;
          r_cnt <= step_delay;
        end
        S_PWR: begin
          if (w_cnt_done) begin
            // Enables turn on strictly in order, so the next step is a shift-in of a 1.
            if (r_en[4]) r_resetn <= 1'b1;
            else         r_en     <= {r_en[3:0], 1'b1};
            r_cnt <= step_delay;
          end else begin
            r_cnt <= r_cnt - DELAY_W'(1);
          end
        end
        S_RELEASE: begin
          if (w_cnt_done) begin
            r_idx     <= '0;
            r_cmd_dat <= init_cmds[31:0];
          end else begin
            r_cnt <= r_cnt - DELAY_W'(1);
          end
        end
        S_CMD: begin
          if (w_cmd_hs) begin
            r_idx     <= r_idx + IDX_W'(1);
            r_cmd_dat <= init_cmds[32*w_sel_idx +: 32];
          end
        end
        default: ;
      endcase
    end
  end

  assign pwr_en     = r_en[0];
  assign ref_en     = r_en[1];
  assign io_en      = r_en[2];
  assign diffamp_en = r_en[3];
  assign opamp_en   = r_en[4];
  assign adc_resetn = r_resetn;
  assign seq_state  = r_state;
  assign ready      = (r_state == S_RUN);

endmodule

// File: tb/tb_adc_power_sequencer.sv
`timescale 1ns/1ps
module tb_adc_power_sequencer;
  localparam int NC = 2;
  localparam int DW = 24;
  localparam logic [31:0] W0 = 32'hC0DE_0001;
  localparam logic [31:0] W1 = 32'hC0DE_0002;
  localparam int EXP_RISE [7] = '{1, 5, 9, 13, 17, 21, 27};

  logic           aclk = 1'b0;
  logic           areset, start, stop;
  logic [DW-1:0]  step_delay;
  logic [32*NC-1:0] init_cmds;
  logic           pwr_en, ref_en, io_en, diffamp_en, opamp_en, adc_resetn;
  logic [31:0]    s_axis_tdata;
  logic           s_axis_tvalid, s_axis_tready;
  logic [31:0]    m_axis_tdata;
  logic           m_axis_tvalid, m_axis_tready;
  logic [2:0]     seq_state;
  logic           ready;

  int errors = 0;
  int checks = 0;

  always #5 aclk = ~aclk;

  adc_power_sequencer #(.NUM_CMDS(NC), .DELAY_W(DW)) dut (
    .aclk(aclk), .areset(areset), .start(start), .stop(stop),
    .step_delay(step_delay), .init_cmds(init_cmds),
    .pwr_en(pwr_en), .ref_en(ref_en), .io_en(io_en), .diffamp_en(diffamp_en),
    .opamp_en(opamp_en), .adc_resetn(adc_resetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .seq_state(seq_state), .ready(ready)
  );

  typedef struct {
    logic        start, stop, tready;
    logic [4:0]  en;
    logic        rn;
    logic [2:0]  st;
    logic        vld;
    logic [31:0] dat;
    logic        srdy;
  } vec_t;
  vec_t tbl[13];

  int rise[7];
  int hs_q[$];

  // reference model state: 0 idle, 1 power/release sequence, 2 init cmds, 3 run, 4 drain init word, 5 drain pass-through
  int m_mode, m_t, m_d, m_idx;
  logic [4:0]  e_en;
  logic        e_rn, e_vld, e_srdy;
  logic [2:0]  e_st;
  logic [31:0] e_dat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] en_v();
    return {opamp_en, diffamp_en, io_en, ref_en, pwr_en};
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic do_reset();
    areset = 1'b1; start = 1'b0; stop = 1'b0;
    m_axis_tready = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = '0;
    cyc(2);
    areset = 1'b0;
  endtask

  // Steps n cycles from a start pulse at cycle 0, recording the first cycle each output is high and handshake cycles.
  task automatic watch(input int n);
    logic [6:0] obs;
    for (int k = 0; k < 7; k++) rise[k] = -1;
    hs_q.delete();
    for (int c = 0; c < n; c++) begin
      #1;
      obs = {ready, adc_resetn, opamp_en, diffamp_en, io_en, ref_en, pwr_en};
      for (int k = 0; k < 7; k++) if (obs[k] && rise[k] < 0) rise[k] = c;
      if (m_axis_tvalid && m_axis_tready) hs_q.push_back(c);
      @(posedge aclk);
      #1;
      start = 1'b0;
    end
  endtask

  task automatic check_t2(input string tag);
    for (int k = 0; k < 7; k++) chk($sformatf("%s_rise%0d", tag, k), rise[k], EXP_RISE[k]);
    chk({tag, "_hs_count"}, hs_q.size(), 2);
    if (hs_q.size() == 2) begin
      chk({tag, "_hs0"}, hs_q[0], 25);
      chk({tag, "_hs1"}, hs_q[1], 26);
    end
  endtask

  task automatic model_expect();
    e_en = '0; e_rn = 1'b0; e_st = 3'd0; e_vld = 1'b0; e_dat = '0; e_srdy = 1'b0;
    case (m_mode)
      1: begin
        for (int k = 0; k < 5; k++) e_en[k] = (m_t >= k * (m_d + 1));
        e_rn = (m_t >= 5 * (m_d + 1));
        e_st = e_rn ? 3'd2 : 3'd1;
      end
      2, 4: begin
        e_en = 5'h1f; e_rn = 1'b1; e_st = (m_mode == 2) ? 3'd3 : 3'd5;
        e_vld = 1'b1; e_dat = init_cmds[32*m_idx +: 32];
      end
      3, 5: begin
        e_en = 5'h1f; e_rn = 1'b1; e_st = (m_mode == 3) ? 3'd4 : 3'd5;
        e_vld = s_axis_tvalid; e_dat = s_axis_tdata; e_srdy = m_axis_tready;
      end
      default: ;
    endcase
  endtask

  task automatic model_step();
    if (areset) m_mode = 0;
    else case (m_mode)
      0: if (start && !stop) begin m_mode = 1; m_t = 0; m_d = int'(step_delay); end
      1: if (stop) m_mode = 0;
         else begin
           m_t++;
           if (m_t == 6 * (m_d + 1)) begin m_mode = 2; m_idx = 0; end
         end
      2: if (stop) m_mode = m_axis_tready ? 0 : 4;
         else if (m_axis_tready) begin
           if (m_idx == NC - 1) m_mode = 3;
           else m_idx++;
         end
      3: if (stop) m_mode = (s_axis_tvalid && !m_axis_tready) ? 5 : 0;
      4: if (m_axis_tready) m_mode = 0;
      5: if (s_axis_tvalid && m_axis_tready) m_mode = 0;
      default: m_mode = 0;
    endcase
  endtask

  initial begin
    init_cmds  = {W1, W0};
    step_delay = 24'd3;

    // T1: reset state
    do_reset();
    #1;
    chk("rst_en", en_v(), 5'b0);
    chk("rst_resetn", adc_resetn, 1'b0);
    chk("rst_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_state", seq_state, 3'd0);
    chk("rst_stready", s_axis_tready, 1'b0);

    // T2: power-up timing with step_delay=3
    m_axis_tready = 1'b1;
    start = 1'b1;
    watch(30);
    check_t2("t2");

    // T4: stop in PWR step 2, then restart repeats the same timing
    do_reset();
    m_axis_tready = 1'b1;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(9);
    #1;
    chk("t4_io_on", io_en, 1'b1);
    chk("t4_diff_off", diffamp_en, 1'b0);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    #1;
    chk("t4_stop_en", en_v(), 5'b0);
    chk("t4_stop_state", seq_state, 3'd0);
    start = 1'b1;
    watch(30);
    check_t2("t4");

    // T3: backpressure during init commands
    do_reset();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(24);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_vld", m_axis_tvalid, 1'b1);
      chk("t3_dat_hold", m_axis_tdata, W0);
      chk("t3_state", seq_state, 3'd3);
      cyc(1);
    end
    m_axis_tready = 1'b1;
    #1;
    chk("t3_hs_dat", m_axis_tdata, W0);
    cyc(1);
    m_axis_tready = 1'b0;
    #1;
    chk("t3_next_word", m_axis_tdata, W1);
    chk("t3_still_cmd", seq_state, 3'd3);
    cyc(2);
    #1;
    chk("t3_word1_hold", m_axis_tdata, W1);
    m_axis_tready = 1'b1;
    cyc(1);
    #1;
    chk("t3_ready", ready, 1'b1);

    // T5: RUN pass-through, then stop with a stalled transfer enters DRAIN
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'hA5A5_0001;
    #1;
    chk("t5_pass_dat", m_axis_tdata, 32'hA5A5_0001);
    chk("t5_pass_vld", m_axis_tvalid, 1'b1);
    chk("t5_pass_rdy", s_axis_tready, 1'b1);
    cyc(1);
    s_axis_tdata  = 32'hA5A5_0002;
    m_axis_tready = 1'b0;
    stop          = 1'b1;
    #1;
    chk("t5_stall_rdy", s_axis_tready, 1'b0);
    cyc(1);
    stop = 1'b0;
    #1;
    chk("t5_drain_state", seq_state, 3'd5);
    chk("t5_drain_dat", m_axis_tdata, 32'hA5A5_0002);
    chk("t5_drain_en", en_v(), 5'h1f);
    cyc(1);
    #1;
    chk("t5_drain_hold", seq_state, 3'd5);
    m_axis_tready = 1'b1;
    #1;
    chk("t5_drain_rdy", s_axis_tready, 1'b1);
    cyc(1);
    s_axis_tvalid = 1'b0;
    #1;
    chk("t5_idle_state", seq_state, 3'd0);
    chk("t5_idle_en", en_v(), 5'b0);
    chk("t5_idle_resetn", adc_resetn, 1'b0);

    // T6: table of per-cycle vectors, step_delay=0 and same-cycle start/stop
    do_reset();
    step_delay = 24'd0;
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 5'b00000, 1'b0, 3'd0, 1'b0, 32'h0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 5'b00000, 1'b0, 3'd0, 1'b0, 32'h0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 5'b00001, 1'b0, 3'd1, 1'b0, 32'h0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 5'b00011, 1'b0, 3'd1, 1'b0, 32'h0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 5'b00111, 1'b0, 3'd1, 1'b0, 32'h0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 5'b01111, 1'b0, 3'd1, 1'b0, 32'h0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 5'b11111, 1'b0, 3'd1, 1'b0, 32'h0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 5'b11111, 1'b1, 3'd2, 1'b0, 32'h0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 5'b11111, 1'b1, 3'd3, 1'b1, W0,    1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 5'b11111, 1'b1, 3'd3, 1'b1, W1,    1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 5'b11111, 1'b1, 3'd4, 1'b0, 32'h0, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 5'b11111, 1'b1, 3'd4, 1'b0, 32'h0, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 5'b00000, 1'b0, 3'd0, 1'b0, 32'h0, 1'b0};
    for (int i = 0; i < 13; i++) begin
      start = tbl[i].start; stop = tbl[i].stop; m_axis_tready = tbl[i].tready;
      #1;
      chk($sformatf("tbl%0d_en", i), en_v(), tbl[i].en);
      chk($sformatf("tbl%0d_resetn", i), adc_resetn, tbl[i].rn);
      chk($sformatf("tbl%0d_state", i), seq_state, tbl[i].st);
      chk($sformatf("tbl%0d_ready", i), ready, tbl[i].st == 3'd4);
      chk($sformatf("tbl%0d_vld", i), m_axis_tvalid, tbl[i].vld);
      chk($sformatf("tbl%0d_srdy", i), s_axis_tready, tbl[i].srdy);
      if (tbl[i].vld) chk($sformatf("tbl%0d_dat", i), m_axis_tdata, tbl[i].dat);
      cyc(1);
    end
    start = 1'b0; stop = 1'b0;

    // Randomized run against the reference model
    do_reset();
    m_mode = 0; m_t = 0; m_d = 0; m_idx = 0;
    for (int cy = 0; cy < 4000; cy++) begin
      if (m_mode == 0 && $urandom_range(0, 7) == 0) step_delay = DW'($urandom_range(0, 3));
      start         = ($urandom_range(0, 9) == 0);
      stop          = ($urandom_range(0, 39) == 0);
      areset        = ($urandom_range(0, 299) == 0);
      m_axis_tready = ($urandom_range(0, 9) < 6);
      s_axis_tvalid = ($urandom_range(0, 1) == 1);
      s_axis_tdata  = $urandom;
      #1;
      model_expect();
      chk("rnd_ctl", {ready, seq_state, adc_resetn, en_v(), m_axis_tvalid, s_axis_tready},
          {e_st == 3'd4, e_st, e_rn, e_en, e_vld, e_srdy});
      if (e_vld) chk("rnd_dat", m_axis_tdata, e_dat);
      model_step();
      @(posedge aclk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
